// File: rtl/pe_local_controller.sv
// Leaf-side controller on a PE's router LOCAL port: decodes root packets, sequences broadcast/compute, reports FINs.
// Optional cycle counters are built only when PE_CTRL_PERF_EN is defined.

`ifndef ROUTER_WIDTH
`define ROUTER_WIDTH 36
`endif
`ifndef ROUTER_FIFO_DEPTH
`define ROUTER_FIFO_DEPTH 4
`endif
`ifndef CREDIT_CNT_WIDTH
`define CREDIT_CNT_WIDTH 4
`endif
`ifndef ROUTER_INFO_CONFIG
`define ROUTER_INFO_CONFIG 4'h1
`endif
`ifndef ROUTER_INFO_CALC
`define ROUTER_INFO_CALC 4'h2
`endif
`ifndef ROUTER_INFO_FIN_BROADCAST
`define ROUTER_INFO_FIN_BROADCAST 4'h3
`endif
`ifndef ROUTER_INFO_FIN_COMP
`define ROUTER_INFO_FIN_COMP 4'h4
`endif

module pe_local_controller #(
  parameter int PE_ID      = 0,
  parameter int FIFO_DEPTH = `ROUTER_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_data_valid,
  input  logic [`ROUTER_WIDTH-1:0] in_data,
  output logic                     upstream_credit,
  output logic                     out_data_valid,
  output logic [`ROUTER_WIDTH-1:0] out_data,
  input  logic                     downstream_credit,
  output logic                     cfg_valid,
  output logic [15:0]              cfg_addr,
  output logic [15:0]              cfg_data,
  output logic                     bcast_start,
  input  logic                     bcast_done,
  output logic                     comp_start,
  input  logic                     comp_done,
  output logic                     busy,
  output logic                     err,
  output logic [31:0]              bcast_cycles,
  output logic [31:0]              comp_cycles
);

  localparam int CW = `CREDIT_CNT_WIDTH;
  localparam logic [CW-1:0] MAX_CREDIT = CW'(FIFO_DEPTH);
  localparam logic [15:0]   PE_DATA    = 16'(PE_ID);

  typedef enum logic [2:0] {
    IDLE,
    BROADCAST,
    SEND_FIN_BCAST,
    WAIT_FIN_BCAST,
    COMP,
    SEND_FIN_COMP,
    WAIT_FIN_COMP
  } state_t;

  state_t          state;
  logic [CW-1:0]   credit_count;
  logic [3:0]      in_info;
  logic            send_state;
  logic            send_fire;
  logic            pkt_ok;
  logic            calc_accept;
  logic [3:0]      fin_info;

  assign in_info    = in_data[35:32];
  assign send_state = (state == SEND_FIN_BCAST) || (state == SEND_FIN_COMP);
  // A credit arriving this cycle can be spent immediately, so a stalled send goes out with it.
  assign send_fire  = send_state && ((credit_count != '0) || downstream_credit);
  assign fin_info   = (state == SEND_FIN_COMP) ? `ROUTER_INFO_FIN_COMP : `ROUTER_INFO_FIN_BROADCAST;
  assign calc_accept = (state == IDLE) && in_data_valid && (in_info == `ROUTER_INFO_CALC);

  assign out_data_valid = send_fire;
  assign out_data       = send_fire ? {fin_info, 16'h0000, PE_DATA} : '0;

  always_comb begin
    pkt_ok = 1'b0;
    unique case (state)
      IDLE:           pkt_ok = (in_info == `ROUTER_INFO_CONFIG) || (in_info == `ROUTER_INFO_CALC);
      WAIT_FIN_BCAST: pkt_ok = (in_info == `ROUTER_INFO_FIN_BROADCAST);
      WAIT_FIN_COMP:  pkt_ok = (in_info == `ROUTER_INFO_FIN_COMP);
      default:        pkt_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      credit_count    <= MAX_CREDIT;
      upstream_credit <= 1'b0;
      cfg_valid       <= 1'b0;
      cfg_addr        <= '0;
      cfg_data        <= '0;
      bcast_start     <= 1'b0;
      comp_start      <= 1'b0;
      busy            <= 1'b0;
      err             <= 1'b0;
    end else begin
      upstream_credit <= in_data_valid;
      cfg_valid       <= 1'b0;
      bcast_start     <= 1'b0;
      comp_start      <= 1'b0;

      if (in_data_valid && !pkt_ok)
        err <= 1'b1;

      // Saturating credit counter; a simultaneous return and send cancel out.
      if (downstream_credit && !send_fire) begin
        if (credit_count != MAX_CREDIT)
          credit_count <= credit_count + CW'(1);
      end else if (send_fire && !downstream_credit) begin
        credit_count <= credit_count - CW'(1);
      end

      unique case (state)
        IDLE: begin
          if (in_data_valid && in_info == `ROUTER_INFO_CONFIG) begin
            cfg_valid <= 1'b1;
            cfg_addr  <= in_data[31:16];
            cfg_data  <= in_data[15:0];
          end
          if (calc_accept) begin
            state       <= BROADCAST;
            bcast_start <= 1'b1;
            busy        <= 1'b1;
          end
        end
        BROADCAST:      if (bcast_done) state <= SEND_FIN_BCAST;
        SEND_FIN_BCAST: if (send_fire) state <= WAIT_FIN_BCAST;
        WAIT_FIN_BCAST: begin
          if (in_data_valid && in_info == `ROUTER_INFO_FIN_BROADCAST) begin
            state      <= COMP;
            comp_start <= 1'b1;
          end
        end
        COMP:           if (comp_done) state <= SEND_FIN_COMP;
        SEND_FIN_COMP:  if (send_fire) state <= WAIT_FIN_COMP;
        WAIT_FIN_COMP: begin
          if (in_data_valid && in_info == `ROUTER_INFO_FIN_COMP) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default:        state <= IDLE;
      endcase
    end
  end

`ifdef PE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst || calc_accept) begin
      bcast_cycles <= '0;
      comp_cycles  <= '0;
    end else begin
      if (state == BROADCAST) bcast_cycles <= bcast_cycles + 32'd1;
      if (state == COMP)      comp_cycles  <= comp_cycles + 32'd1;
    end
  end
`else
  assign bcast_cycles = '0;
  assign comp_cycles  = '0;
`endif

endmodule
